// File: rtl/pwm_pkg.sv
// pwm_pkg: constants shared between the PWM generator and decoder, plus the
// decoder FSM state type.
//   DEFAULT_PERIOD : frame length in clock cycles
//   DUTY_W         : width of a duty level (0..PERIOD encoding)
//   state_e        : decoder frame-tracking state

package pwm_pkg;

    localparam int unsigned DEFAULT_PERIOD = 10;
    localparam int unsigned DUTY_W         = 4;

    typedef enum logic {
        SEARCH  = 1'b0,  // no frame reference yet
        MEASURE = 1'b1   // counting inside a frame
    } state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: brings the asynchronous PWM input into the clock domain and
// detects its rising edges.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   pwm_i   : asynchronous PWM input
//   sync_o  : synchronized input level (two flops deep)
//   rise_o  : one-cycle pulse on a synchronized 0->1 transition

module pwm_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pwm_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= pwm_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures a PWM waveform frame by frame (rising edge to rising
// edge) and reports the number of high cycles per frame. A missing rising edge
// for TIMEOUT cycles produces a steady-level report instead.
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   pwm_sig_i    : asynchronous PWM input
//   duty_level_o : last measured high-cycle count (saturating)
//   valid_o      : one-cycle pulse when a report is made
//   period_err_o : last report's frame length differed from PERIOD
//   locked_o     : a good-period report since reset/error/timeout
// TIMEOUT must be greater than PERIOD.

module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD  = DEFAULT_PERIOD,
    parameter int unsigned TIMEOUT = 20,
    parameter int unsigned LVL_W   = DUTY_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pwm_sig_i,
    output logic [LVL_W-1:0] duty_level_o,
    output logic             valid_o,
    output logic             period_err_o,
    output logic             locked_o
);

    localparam int unsigned      CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_PERIOD = CNT_W'(PERIOD);
    localparam int unsigned      LVL_MAX    = (1 << LVL_W) - 1;
    localparam logic [LVL_W-1:0] LVL_HIGH   = (PERIOD > LVL_MAX) ? LVL_W'(LVL_MAX)
                                                                 : LVL_W'(PERIOD);

    logic sync;
    logic rise;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [LVL_W-1:0] duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;

    logic             frame_close;
    logic             timeout;
    logic [LVL_W-1:0] high_lvl;

    pwm_edge_sync u_edge_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .pwm_i  (pwm_sig_i),
        .sync_o (sync),
        .rise_o (rise)
    );

    // period_cnt doubles as the idle counter in SEARCH. The timeout fires on
    // the cycle the count would reach TIMEOUT; a coincident rise takes priority.
    assign timeout     = ~rise & (period_cnt_q >= CNT_LAST);
    assign frame_close = rise & (state_q == MEASURE);
    assign high_lvl    = (32'(high_cnt_q) > LVL_MAX) ? LVL_W'(LVL_MAX) : LVL_W'(high_cnt_q);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counters
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        if (rise) begin
            // The rise cycle itself is the first (high) cycle of the new frame.
            state_d      = MEASURE;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
        end else if (timeout) begin
            state_d      = SEARCH;
            period_cnt_d = '0;
            high_cnt_d   = '0;
        end else begin
            if (period_cnt_q != CNT_MAX) begin
                period_cnt_d = period_cnt_q + CNT_ONE;
            end
            if ((state_q == MEASURE) && sync && (high_cnt_q != CNT_MAX)) begin
                high_cnt_d = high_cnt_q + CNT_ONE;
            end
        end
    end

    // Report outputs (registered below)
    always_comb begin
        valid_d  = frame_close | timeout;
        duty_d   = duty_q;
        err_d    = err_q;
        locked_d = locked_q;
        if (frame_close) begin
            duty_d   = high_lvl;
            err_d    = (period_cnt_q != CNT_PERIOD);
            locked_d = (period_cnt_q == CNT_PERIOD);
        end else if (timeout) begin
            duty_d   = sync ? LVL_HIGH : '0;
            err_d    = 1'b0;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            duty_q       <= duty_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
        end
    end

    assign duty_level_o = duty_q;
    assign valid_o      = valid_q;
    assign period_err_o = err_q;
    assign locked_o     = locked_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Testbench for pwm_decoder: drives PWM frames, queues the expected report
// for each frame close, and compares every valid_o pulse against the queue.

module tb_pwm_decoder;

    localparam int PERIOD  = 10;
    localparam int TIMEOUT = 20;
    localparam int LVL_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm = 1'b0;
    logic [LVL_W-1:0] duty_level;
    logic             valid;
    logic             period_err;
    logic             locked;

    always #5 clk = ~clk;

    pwm_decoder #(
        .PERIOD  (PERIOD),
        .TIMEOUT (TIMEOUT),
        .LVL_W   (LVL_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pwm_sig_i    (pwm),
        .duty_level_o (duty_level),
        .valid_o      (valid),
        .period_err_o (period_err),
        .locked_o     (locked)
    );

    typedef struct {
        int level;
        bit err;
        bit lk;
    } rpt_t;

    typedef struct {
        int len;
        int high;
        int frames;
        int level;
        bit err;
        bit lk;
    } vec_t;

    rpt_t exp_q[$];
    int   vcyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: every report is popped and compared as it appears.
    always begin
        rpt_t e;
        @(posedge clk);
        #1;
        if (valid === 1'b1) begin
            vcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("duty_level", int'(duty_level), e.level);
                chk("period_err", int'(period_err), int'(e.err));
                chk("locked", int'(locked), int'(e.lk));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_rpt(input int lvl, input bit err, input bit lk);
        rpt_t r;
        r.level = lvl;
        r.err   = err;
        r.lk    = lk;
        exp_q.push_back(r);
    endtask

    task automatic do_reset();
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
        rst_n = 1'b0;
        pwm   = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic frame(input int len, input int high);
        for (int c = 0; c < len; c++) begin
            pwm = (c < high);
            tick(1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   rel;

        vecs[0] = '{10, 3, 4, 3, 1'b0, 1'b1};
        vecs[1] = '{10, 5, 4, 5, 1'b0, 1'b1};
        vecs[2] = '{10, 1, 4, 1, 1'b0, 1'b1};
        vecs[3] = '{10, 9, 4, 9, 1'b0, 1'b1};
        vecs[4] = '{19, 18, 3, 15, 1'b1, 1'b0};  // rise on the timeout cycle; saturated level
        vecs[5] = '{8, 4, 4, 4, 1'b1, 1'b0};     // short frames

        tick(1);
        do_reset();
        chk("rst_duty", int'(duty_level), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_err", int'(period_err), 0);
        chk("rst_locked", int'(locked), 0);

        // Steady frames: each rise after the first closes a frame.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int f = 0; f < vecs[i].frames; f++) begin
                if (f > 0) expect_rpt(vecs[i].level, vecs[i].err, vecs[i].lk);
                frame(vecs[i].len, vecs[i].high);
            end
        end

        // Duty step 3 -> 7 during the high part of frame 3.
        do_reset();
        for (int f = 0; f < 7; f++) begin
            if (f > 0) expect_rpt((f - 1 < 3) ? 3 : 7, 1'b0, 1'b1);
            if (f < 3) begin
                frame(10, 3);
            end else if (f == 3) begin
                for (int c = 0; c < 10; c++) begin
                    pwm = (c < ((c < 2) ? 3 : 7));
                    tick(1);
                end
            end else begin
                frame(10, 7);
            end
        end
        chk("step_locked", int'(locked), 1);

        // 12-cycle frames, then back to 10-cycle frames.
        do_reset();
        for (int f = 0; f < 7; f++) begin
            if (f > 0) begin
                if (f <= 4) expect_rpt(5, 1'b1, 1'b0);
                else        expect_rpt(5, 1'b0, 1'b1);
            end
            if (f < 4) frame(12, 5);
            else       frame(10, 5);
        end

        // Constant low: reports 20 cycles after reset release, then every 20.
        do_reset();
        rel = cyc;
        vcyc.delete();
        expect_rpt(0, 1'b0, 1'b0);
        expect_rpt(0, 1'b0, 1'b0);
        tick(45);
        chk("low_reports", vcyc.size(), 2);
        if (vcyc.size() >= 2) begin
            chk("low_first_at", vcyc[0] - rel, TIMEOUT);
            chk("low_interval", vcyc[1] - vcyc[0], TIMEOUT);
        end

        // Constant high (duty 12 clamps): first rise, then timeout reports.
        do_reset();
        rel = cyc;
        vcyc.delete();
        expect_rpt(PERIOD, 1'b0, 1'b0);
        expect_rpt(PERIOD, 1'b0, 1'b0);
        for (int f = 0; f < 5; f++) frame(10, 12);
        chk("high_reports", vcyc.size(), 2);
        if (vcyc.size() >= 2) begin
            chk("high_first_at", vcyc[0] - rel, TIMEOUT + 2);
            chk("high_interval", vcyc[1] - vcyc[0], TIMEOUT);
        end

        // Reset mid-frame: immediate clear, no report for the aborted frame.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            if (f > 0) expect_rpt(3, 1'b0, 1'b1);
            frame(10, 3);
        end
        expect_rpt(3, 1'b0, 1'b1);
        frame(5, 3);
        chk("pre_rst_pending", exp_q.size(), 0);
        chk("pre_rst_locked", int'(locked), 1);
        rst_n = 1'b0;
        pwm   = 1'b0;
        #1;
        chk("midrst_duty", int'(duty_level), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_err", int'(period_err), 0);
        chk("midrst_locked", int'(locked), 0);
        tick(2);
        rst_n = 1'b1;
        vcyc.delete();
        for (int f = 0; f < 3; f++) begin
            if (f > 0) expect_rpt(3, 1'b0, 1'b1);
            frame(10, 3);
        end
        chk("post_rst_reports", vcyc.size(), 2);

        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Measures an incoming PWM waveform and recovers its duty level. The level uses the same 0..PERIOD encoding our PWM generator drives, where duty level N means N high cycles per PERIOD-cycle frame. The block sits on the receive side of a PWM link, or on a loopback path used for self-check. It reports one level per frame, flags frames whose period is wrong, and detects constant-low and constant-high inputs by timeout.

## Interface
- PERIOD, default 10: expected frame length in clk_i cycles.
- TIMEOUT, default 20: cycles without a rising edge before a steady-level report; must be > PERIOD.
- LVL_W, default 4: width of duty_level_o.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- pwm_sig_i  in  1  PWM input, asynchronous to clk_i.
- duty_level_o  out  LVL_W  last measured high-cycle count; saturates at 2^LVL_W-1.
- valid_o  out  1  one-cycle pulse when duty_level_o/period_err_o update.
- period_err_o  out  1  last report's frame length != PERIOD (timeout reports: 0).
- locked_o  out  1  a report with correct period has been made since reset/last error/last timeout.

## Operation
- Input path: 2-flop synchronizer, then a delay flop (prev). rise = sync & ~prev.
- Counters: period_cnt and high_cnt, each CNT_W = $clog2(TIMEOUT+1) bits, both saturating at TIMEOUT.
- FSM has two states.
  - SEARCH, entered at reset: no frame reference yet.
  - MEASURE: counting within a frame.
- SEARCH + rise:
  - Enter MEASURE with period_cnt=1 and high_cnt=1.
  - No report is made.
- MEASURE without rise:
  - period_cnt += 1.
  - high_cnt += sync.
- MEASURE + rise (frame closes):
  - Report duty_level_o = min(high_cnt, 2^LVL_W-1) and period_err_o = (period_cnt != PERIOD).
  - Pulse valid_o.
  - Reload period_cnt=1 and high_cnt=1, staying in MEASURE.
  - locked_o is set if period_err_o=0, cleared otherwise.
- Timeout, in either state (period_cnt, or the idle counter in SEARCH, reaches TIMEOUT with no rise):
  - Report duty_level_o = sync ? PERIOD : 0, with period_err_o=0.
  - Pulse valid_o and clear locked_o.
  - Go to SEARCH and restart the timeout count at 0.
  - A constant input therefore repeats its report every TIMEOUT cycles.
- Rise and timeout in the same cycle: rise wins.
- duty_level_o and period_err_o hold between reports.

## Timing
- Reset values: duty_level_o=0, valid_o=0, period_err_o=0, locked_o=0, state=SEARCH, all counters 0, synchronizer and prev flops 0.
- Latency: if edge E is the first to sample pwm_sig_i high (closing a frame), valid_o is high in the cycle after edge E+2. That is 2 cycles of sync/edge latency plus a registered output.
- Report cadence on a steady PERIOD-cycle input: one valid_o every PERIOD cycles, starting from the second observed rising edge.
- A duty change takes effect in the first fully new frame. The frame containing the change reports a mixed count.
- Glitches shorter than one clk_i cycle may be missed. Glitches that are captured count as edges and yield period_err_o=1.
- Asserting rst_ni low mid-frame clears everything immediately. No partial report is made.

## Structure
- Shared package pwm_pkg holds DEFAULT_PERIOD=10 and the duty-level width constant, shared with the generator, plus the FSM state enum {SEARCH, MEASURE}.
- One sub-module, pwm_edge_sync: 2-flop synchronizer plus delay flop, outputting sync and rise.
- Counters, FSM and output registers stay in pwm_decoder.

## Test plan
- Generator loopback, duty 3: after 2 frames, valid_o every 10 cycles with duty_level_o=3, period_err_o=0, locked_o=1.
- Duty 0 (constant low): no rise; valid_o at TIMEOUT (cycle 20) and every 20 after, with duty_level_o=0 and locked_o=0.
- Duty 12 (constant high): reports at 20-cycle intervals with duty_level_o=10 and period_err_o=0.
- Duty step 3→7 mid-frame: one transitional report, then steady 7s, with locked_o staying 1 throughout.
- Hand-built 12-cycle frames, 5 high: duty_level_o=5, period_err_o=1, locked_o=0. Returning to 10-cycle frames sets locked_o=1 on the first good report.
- rst_ni pulsed low mid-frame: all outputs 0 at once, no valid_o for the aborted frame, and a correct report after 2 new frames.
